// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the five-stage OTTER pipeline: load-use stalls, branch/jump flushes,
// operand forwarding selects and a saturating stall counter. Macro HAZARD_FORWARD_EN enables forwarding.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             HAZARD_CLOCK,
  input  logic             HAZARD_RESET,
  input  logic [4:0]       ID_RS1_ADDR,
  input  logic [4:0]       ID_RS2_ADDR,
  input  logic             ID_RS1_USED,
  input  logic             ID_RS2_USED,
  input  logic [4:0]       DR_RS1_ADDR,
  input  logic [4:0]       DR_RS2_ADDR,
  input  logic [4:0]       DR_RD_ADDR,
  input  logic             DR_REG_WRITE,
  input  logic             DR_MEM_READ2,
  input  logic [4:0]       EXEC_RD_ADDR,
  input  logic             EXEC_REGWRITE,
  input  logic [4:0]       WB_RD_ADDR,
  input  logic             WB_REGWRITE,
  input  logic [1:0]       PCSOURCE_TO_PC,
  output logic             FETCH_STALL,
  output logic             DECODE_STALL,
  output logic             FETCH_FLUSH,
  output logic             DECODE_FLUSH,
  output logic [1:0]       FWD_A_SEL,
  output logic [1:0]       FWD_B_SEL,
  output logic [CNT_W-1:0] STALL_CNT
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    REDIRECT   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_redirect;
  logic             w_hazard;
  logic             w_id1_dr;
  logic             w_id2_dr;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  // x0 is hardwired zero, so it never creates a dependency
  function automatic logic addr_hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  assign w_redirect = (r_state != REDIRECT) && (PCSOURCE_TO_PC != 2'd0);
  assign w_id1_dr   = ID_RS1_USED && addr_hit(ID_RS1_ADDR, DR_RD_ADDR);
  assign w_id2_dr   = ID_RS2_USED && addr_hit(ID_RS2_ADDR, DR_RD_ADDR);

`ifdef HAZARD_FORWARD_EN
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] ex_rd,
                                         input logic ex_we, input logic [4:0] wb_rd,
                                         input logic wb_we);
    logic [1:0] sel;
    if (ex_we && addr_hit(src, ex_rd)) begin
      sel = 2'd1;
    end else if (wb_we && addr_hit(src, wb_rd)) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // The stall cycle already pushed a bubble into the decode register, so never stall twice
  assign w_hazard = DR_MEM_READ2 && DR_REG_WRITE && (r_state != LOAD_STALL) && (w_id1_dr || w_id2_dr);
  assign w_fwd_a  = fwd_sel(DR_RS1_ADDR, EXEC_RD_ADDR, EXEC_REGWRITE, WB_RD_ADDR, WB_REGWRITE);
  assign w_fwd_b  = fwd_sel(DR_RS2_ADDR, EXEC_RD_ADDR, EXEC_REGWRITE, WB_RD_ADDR, WB_REGWRITE);
`else
  logic w_id1_ex;
  logic w_id2_ex;
  logic w_unused_fwd;

  assign w_id1_ex = ID_RS1_USED && addr_hit(ID_RS1_ADDR, EXEC_RD_ADDR);
  assign w_id2_ex = ID_RS2_USED && addr_hit(ID_RS2_ADDR, EXEC_RD_ADDR);
  // Without forwarding, wait until the producer reaches writeback (regfile write-before-read)
  assign w_hazard = (DR_REG_WRITE && (w_id1_dr || w_id2_dr)) ||
                    (EXEC_REGWRITE && (w_id1_ex || w_id2_ex));
  assign w_fwd_a  = 2'd0;
  assign w_fwd_b  = 2'd0;
  assign w_unused_fwd = ^{DR_RS1_ADDR, DR_RS2_ADDR, DR_MEM_READ2, WB_RD_ADDR, WB_REGWRITE};
`endif

  // Stall/flush/select decode; redirect outranks stall, reset forces everything quiet
  always_comb begin
    FETCH_STALL  = 1'b0;
    DECODE_STALL = 1'b0;
    FETCH_FLUSH  = 1'b0;
    DECODE_FLUSH = 1'b0;
    FWD_A_SEL    = 2'd0;
    FWD_B_SEL    = 2'd0;
    w_next_state = RUN;
    if (HAZARD_RESET) begin
      w_next_state = RUN;
    end else begin
      FWD_A_SEL = w_fwd_a;
      FWD_B_SEL = w_fwd_b;
      if (w_redirect) begin
        FETCH_FLUSH  = 1'b1;
        DECODE_FLUSH = 1'b1;
        w_next_state = REDIRECT;
      end else if (w_hazard) begin
        FETCH_STALL  = 1'b1;
        DECODE_STALL = 1'b1;
        DECODE_FLUSH = 1'b1;
        w_next_state = LOAD_STALL;
      end else begin
        w_next_state = RUN;
      end
    end
  end

  // Controller state and saturating stall-cycle counter
  always_ff @(posedge HAZARD_CLOCK or posedge HAZARD_RESET) begin
    if (HAZARD_RESET) begin
      r_state     <= RUN;
      r_stall_cnt <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      if (FETCH_STALL && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign STALL_CNT = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven bench for pipeline_hazard_ctrl with a queue scoreboard; expectations
// follow whichever build (HAZARD_FORWARD_EN defined or not) is compiled.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;
`ifdef HAZARD_FORWARD_EN
  localparam bit FW = 1'b1;
`else
  localparam bit FW = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [4:0] ir1; logic u1; logic [4:0] ir2; logic u2;
    logic [4:0] d1; logic [4:0] d2; logic [4:0] drd; logic dwr; logic dld;
    logic [4:0] erd; logic ewr; logic [4:0] wrd; logic wwr;
    logic [1:0] pc;
    logic [3:0] st;   // {fetch_stall, decode_stall, fetch_flush, decode_flush}
    logic [1:0] fa; logic [1:0] fb;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs1, id_rs2, dr_rs1, dr_rs2, dr_rd, ex_rd, wb_rd;
  logic          id_u1, id_u2, dr_wr, dr_ld, ex_wr, wb_wr;
  logic [1:0]    pcs;
  logic          fstall, dstall, fflush, dflush;
  logic [1:0]    fwa, fwb;
  logic [CW-1:0] cnt;

  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_cnt = '0;
  vec_t          vq[$];
  vec_t          sb[$];

  pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
    .HAZARD_CLOCK(clk), .HAZARD_RESET(rst),
    .ID_RS1_ADDR(id_rs1), .ID_RS2_ADDR(id_rs2), .ID_RS1_USED(id_u1), .ID_RS2_USED(id_u2),
    .DR_RS1_ADDR(dr_rs1), .DR_RS2_ADDR(dr_rs2), .DR_RD_ADDR(dr_rd),
    .DR_REG_WRITE(dr_wr), .DR_MEM_READ2(dr_ld),
    .EXEC_RD_ADDR(ex_rd), .EXEC_REGWRITE(ex_wr), .WB_RD_ADDR(wb_rd), .WB_REGWRITE(wb_wr),
    .PCSOURCE_TO_PC(pcs),
    .FETCH_STALL(fstall), .DECODE_STALL(dstall), .FETCH_FLUSH(fflush), .DECODE_FLUSH(dflush),
    .FWD_A_SEL(fwa), .FWD_B_SEL(fwb), .STALL_CNT(cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t V(input string n,
      input logic [4:0] ir1, input logic u1, input logic [4:0] ir2, input logic u2,
      input logic [4:0] d1, input logic [4:0] d2, input logic [4:0] drd, input logic dwr, input logic dld,
      input logic [4:0] erd, input logic ewr, input logic [4:0] wrd, input logic wwr,
      input logic [1:0] pc, input logic [3:0] st, input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.name = n; v.ir1 = ir1; v.u1 = u1; v.ir2 = ir2; v.u2 = u2;
    v.d1 = d1; v.d2 = d2; v.drd = drd; v.dwr = dwr; v.dld = dld;
    v.erd = erd; v.ewr = ewr; v.wrd = wrd; v.wwr = wwr; v.pc = pc;
    v.st = st; v.fa = fa; v.fb = fb;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs1 = v.ir1; id_u1 = v.u1; id_rs2 = v.ir2; id_u2 = v.u2;
    dr_rs1 = v.d1; dr_rs2 = v.d2; dr_rd = v.drd; dr_wr = v.dwr; dr_ld = v.dld;
    ex_rd = v.erd; ex_wr = v.ewr; wb_rd = v.wrd; wb_wr = v.wwr; pcs = v.pc;
  endtask

  // One pipeline cycle: drive after the rising edge, check at the falling edge
  task automatic apply(input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    drive(v);
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.name, ".fetch_stall"},  {31'd0, fstall}, {31'd0, e.st[3]});
    chk({e.name, ".decode_stall"}, {31'd0, dstall}, {31'd0, e.st[2]});
    chk({e.name, ".fetch_flush"},  {31'd0, fflush}, {31'd0, e.st[1]});
    chk({e.name, ".decode_flush"}, {31'd0, dflush}, {31'd0, e.st[0]});
    chk({e.name, ".fwd_a"}, {30'd0, fwa}, {30'd0, e.fa});
    chk({e.name, ".fwd_b"}, {30'd0, fwb}, {30'd0, e.fb});
    chk({e.name, ".stall_cnt"}, {28'd0, cnt}, {28'd0, exp_cnt});
    if (e.st[3] && (exp_cnt != 4'hF)) exp_cnt = exp_cnt + 4'd1;
  endtask

  vec_t zv, luv;

  initial begin
    zv  = V("zero",   5'd0,1'b0,5'd0,1'b0, 5'd0,5'd0,5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0, 2'd0, 4'b0000, 2'd0,2'd0);
    luv = V("rst_lu", 5'd5,1'b1,5'd0,1'b0, 5'd0,5'd0,5'd5,1'b1,1'b1, 5'd0,1'b0, 5'd0,1'b0, 2'd0, 4'b1101, 2'd0,2'd0);

    vq.push_back(V("idle",      5'd0,1'b0,5'd0,1'b0, 5'd0,5'd0,5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0, 2'd0, 4'b0000, 2'd0,2'd0));
    vq.push_back(V("lu_x5",     5'd5,1'b1,5'd0,1'b0, 5'd0,5'd0,5'd5,1'b1,1'b1, 5'd0,1'b0, 5'd0,1'b0, 2'd0, 4'b1101, 2'd0,2'd0));
    vq.push_back(V("lu_x5_b",   5'd5,1'b1,5'd0,1'b0, 5'd0,5'd0,5'd0,1'b0,1'b0, 5'd5,1'b1, 5'd0,1'b0, 2'd0, FW ? 4'b0000 : 4'b1101, 2'd0,2'd0));
    if (!FW)
      vq.push_back(V("lu_x5_c", 5'd5,1'b1,5'd0,1'b0, 5'd0,5'd0,5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd5,1'b1, 2'd0, 4'b0000, 2'd0,2'd0));
    vq.push_back(V("lu_x5_fwd", 5'd0,1'b0,5'd0,1'b0, 5'd5,5'd0,5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd5,1'b1, 2'd0, 4'b0000, FW ? 2'd2 : 2'd0,2'd0));
    vq.push_back(V("x0_load",   5'd0,1'b1,5'd0,1'b1, 5'd0,5'd0,5'd0,1'b1,1'b1, 5'd0,1'b1, 5'd0,1'b1, 2'd0, 4'b0000, 2'd0,2'd0));
    vq.push_back(V("redir",     5'd0,1'b0,5'd0,1'b0, 5'd0,5'd0,5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0, 2'd2, 4'b0011, 2'd0,2'd0));
    vq.push_back(V("redir_ign", 5'd0,1'b0,5'd0,1'b0, 5'd0,5'd0,5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0, 2'd3, 4'b0000, 2'd0,2'd0));
    vq.push_back(V("redir_end", 5'd0,1'b0,5'd0,1'b0, 5'd0,5'd0,5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0, 2'd0, 4'b0000, 2'd0,2'd0));
    vq.push_back(V("lu_redir",  5'd5,1'b1,5'd0,1'b0, 5'd0,5'd0,5'd5,1'b1,1'b1, 5'd0,1'b0, 5'd0,1'b0, 2'd1, 4'b0011, 2'd0,2'd0));
    vq.push_back(V("post_redir",5'd0,1'b0,5'd0,1'b0, 5'd0,5'd0,5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0, 2'd0, 4'b0000, 2'd0,2'd0));
    vq.push_back(V("fwd_prio",  5'd0,1'b0,5'd7,1'b1, 5'd0,5'd7,5'd7,1'b1,1'b0, 5'd7,1'b1, 5'd7,1'b1, 2'd0, FW ? 4'b0000 : 4'b1101, 2'd0, FW ? 2'd1 : 2'd0));
    if (!FW) begin
      vq.push_back(V("nf_x7_b", 5'd0,1'b0,5'd7,1'b1, 5'd0,5'd0,5'd0,1'b0,1'b0, 5'd7,1'b1, 5'd7,1'b1, 2'd0, 4'b1101, 2'd0,2'd0));
      vq.push_back(V("nf_x7_c", 5'd0,1'b0,5'd7,1'b1, 5'd0,5'd0,5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd7,1'b1, 2'd0, 4'b0000, 2'd0,2'd0));
      vq.push_back(V("nf_x7_d", 5'd0,1'b0,5'd0,1'b0, 5'd0,5'd7,5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0, 2'd0, 4'b0000, 2'd0,2'd0));
    end
    vq.push_back(V("fwd_wb",    5'd0,1'b0,5'd0,1'b0, 5'd9,5'd0,5'd0,1'b0,1'b0, 5'd3,1'b1, 5'd9,1'b1, 2'd0, 4'b0000, FW ? 2'd2 : 2'd0,2'd0));
    vq.push_back(V("fwd_ex2",   5'd0,1'b0,5'd0,1'b0, 5'd4,5'd4,5'd0,1'b0,1'b0, 5'd4,1'b1, 5'd4,1'b0, 2'd0, 4'b0000, FW ? 2'd1 : 2'd0, FW ? 2'd1 : 2'd0));
    vq.push_back(V("fwd_exoff", 5'd0,1'b0,5'd0,1'b0, 5'd6,5'd0,5'd0,1'b0,1'b0, 5'd6,1'b0, 5'd6,1'b1, 2'd0, 4'b0000, FW ? 2'd2 : 2'd0,2'd0));
    vq.push_back(V("unused_src",5'd6,1'b0,5'd6,1'b0, 5'd0,5'd0,5'd6,1'b1,1'b1, 5'd0,1'b0, 5'd0,1'b0, 2'd0, 4'b0000, 2'd0,2'd0));
    vq.push_back(V("lu_rs2",    5'd0,1'b0,5'd8,1'b1, 5'd0,5'd0,5'd8,1'b1,1'b1, 5'd0,1'b0, 5'd0,1'b0, 2'd0, 4'b1101, 2'd0,2'd0));
    vq.push_back(V("lu_rs2_b",  5'd0,1'b0,5'd0,1'b0, 5'd0,5'd0,5'd0,1'b0,1'b0, 5'd8,1'b1, 5'd0,1'b0, 2'd0, 4'b0000, 2'd0,2'd0));
    vq.push_back(V("alu_dep",   5'd3,1'b1,5'd0,1'b0, 5'd0,5'd0,5'd3,1'b1,1'b0, 5'd0,1'b0, 5'd0,1'b0, 2'd0, FW ? 4'b0000 : 4'b1101, 2'd0,2'd0));
    vq.push_back(V("tail",      5'd0,1'b0,5'd0,1'b0, 5'd0,5'd0,5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0, 2'd0, 4'b0000, 2'd0,2'd0));

    // Power-on reset with a hazard and a redirect pending: outputs must stay quiet
    rst = 1'b1;
    drive(luv);
    pcs = 2'd1;
    dr_rs1 = 5'd5; ex_rd = 5'd5; ex_wr = 1'b1;
    #3;
    chk("por.fetch_stall", {31'd0, fstall}, 32'd0);
    chk("por.fetch_flush", {31'd0, fflush}, 32'd0);
    chk("por.decode_flush", {31'd0, dflush}, 32'd0);
    chk("por.fwd_a", {30'd0, fwa}, 32'd0);
    chk("por.stall_cnt", {28'd0, cnt}, 32'd0);
    drive(zv);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) apply(vq[i]);

    // Reset in the middle of a load stall
    apply(luv);
    @(posedge clk);
    #1;
    rst = 1'b1;
    pcs = 2'd1;
    #1;
    exp_cnt = '0;
    chk("rst_ls.fetch_stall", {31'd0, fstall}, 32'd0);
    chk("rst_ls.decode_stall", {31'd0, dstall}, 32'd0);
    chk("rst_ls.fetch_flush", {31'd0, fflush}, 32'd0);
    chk("rst_ls.decode_flush", {31'd0, dflush}, 32'd0);
    chk("rst_ls.stall_cnt", {28'd0, cnt}, 32'd0);
    drive(zv);
    @(negedge clk);
    rst = 1'b0;
    apply(V("rst_next", 5'd0,1'b0,5'd0,1'b0, 5'd0,5'd0,5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0, 2'd0, 4'b0000, 2'd0,2'd0));
    apply(luv);
    apply(zv);

    // Reset in the middle of a redirect
    apply(V("rst_redir", 5'd0,1'b0,5'd0,1'b0, 5'd0,5'd0,5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0, 2'd1, 4'b0011, 2'd0,2'd0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_cnt = '0;
    chk("rst_rd.fetch_flush", {31'd0, fflush}, 32'd0);
    chk("rst_rd.decode_flush", {31'd0, dflush}, 32'd0);
    chk("rst_rd.stall_cnt", {28'd0, cnt}, 32'd0);
    drive(zv);
    @(negedge clk);
    rst = 1'b0;
    apply(V("rst_redir2", 5'd0,1'b0,5'd0,1'b0, 5'd0,5'd0,5'd0,1'b0,1'b0, 5'd0,1'b0, 5'd0,1'b0, 2'd1, 4'b0011, 2'd0,2'd0));
    apply(zv);

    // Hold a load-use hazard for 2*(2^CW+3) cycles: at least 2^CW+3 of them stall
    @(posedge clk);
    #1;
    drive(luv);
    repeat (2 * ((1 << CW) + 3)) @(posedge clk);
    #1;
    chk("sat.stall_cnt", {28'd0, cnt}, {28'd0, {CW{1'b1}}});
    @(posedge clk);
    #1;
    chk("sat_hold.stall_cnt", {28'd0, cnt}, {28'd0, {CW{1'b1}}});
    drive(zv);
    @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
